// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised multi-port register file for the pipelined core.
//   - NRD combinational read ports with optional write-through bypass
//   - two write ports, port 1 wins on an address collision
//   - per-entry scoreboard (busy) set from decode, cleared by writeback
//   - sequential clear engine sweeping one entry per cycle
// Ports:
//   clk, rst_n          clock, async active-low reset
//   rd_addr / rd_data   packed read ports, port k at [k*W +: W]
//   we0/waddr0/wdata0   write port 0
//   we1/waddr1/wdata1   write port 1 (priority)
//   sb_set / sb_addr    scoreboard set
//   busy                scoreboard bits, one per entry
//   clr_req / clr_busy  clear engine start pulse / running flag
module reg_file_mp #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NRD     = 4,
  parameter bit ZERO_R0 = 1'b1,
  parameter bit BYPASS  = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NRD*ADDR_W-1:0]    rd_addr,
  output logic [NRD*DATA_W-1:0]    rd_data,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_addr,
  output logic [(1<<ADDR_W)-1:0]   busy,
  input  logic                     clr_req,
  output logic                     clr_busy
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {S_IDLE, S_CLEAR} state_e;

  state_e                        state_q, state_d;
  logic [ADDR_W-1:0]             idx_q, idx_d;
  logic [DEPTH-1:0][DATA_W-1:0]  mem_q, mem_d;
  logic [DEPTH-1:0]              busy_q, busy_d;

  logic we0_eff, we1_eff, byp_en;

  // Writes to entry 0 are dropped entirely when it is hardwired to zero,
  // so they neither update the array nor feed the bypass.
  assign we0_eff = we0 && !(ZERO_R0 && (waddr0 == '0));
  assign we1_eff = we1 && !(ZERO_R0 && (waddr1 == '0));

  // While clearing, the array is the only truth: no forwarding.
  assign byp_en  = BYPASS && (state_q == S_IDLE);

  assign busy     = busy_q;
  assign clr_busy = (state_q == S_CLEAR);

  // ---------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;

    assign a = rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      d = mem_q[a];
      if (byp_en) begin
        // port 1 checked last so it overrides a port-0 match
        if (we0_eff && (waddr0 == a)) d = wdata0;
        if (we1_eff && (waddr1 == a)) d = wdata1;
      end
      if (ZERO_R0 && (a == '0)) d = '0;
    end

    assign rd_data[k*DATA_W +: DATA_W] = d;
  end

  // ---------------------------------------------------------------------
  // Next state: writes, scoreboard, clear engine
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mem_d   = mem_q;
    busy_d  = busy_q;

    case (state_q)
      S_IDLE: begin
        if (we0_eff) mem_d[waddr0] = wdata0;
        if (we1_eff) mem_d[waddr1] = wdata1;
        if (we0_eff) busy_d[waddr0] = 1'b0;
        if (we1_eff) busy_d[waddr1] = 1'b0;
        // a fresh producer issued this cycle outranks the retiring write
        if (sb_set)  busy_d[sb_addr] = 1'b1;
        if (clr_req) begin
          state_d = S_CLEAR;
          idx_d   = '0;
        end
      end
      S_CLEAR: begin
        mem_d[idx_q]  = '0;
        busy_d[idx_q] = 1'b0;
        // index is exactly ADDR_W bits, so the increment after the last
        // entry wraps back to 0 for the next clear
        idx_d = idx_q + 1'b1;
        if (&idx_q) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase

    if (ZERO_R0) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      mem_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mem_q   <= mem_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-port register file for the pipelined successor of the single-cycle core.
- Generalised in data width, depth and read-port count; adds two write ports with priority, optional write-through bypass, a per-register scoreboard (pending-write bits) and a sequential clear engine.
- Sits between decode (reads, scoreboard set) and writeback (two retire ports).
- Debug and LED taps are plain read ports.

Parameters:
- DATA_W, 32: register width in bits.
- ADDR_W, 5: address width; DEPTH = 2**ADDR_W entries.
- NRD, 4: number of combinational read ports.
- ZERO_R0, 1: 1 = entry 0 reads 0, ignores writes, never marked busy.
- BYPASS, 1: 1 = a read matching a same-cycle enabled write returns the write data.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- rd_addr  in  NRD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NRD*DATA_W  read data; port k uses bits [k*DATA_W +: DATA_W].
- we0  in  1  write-port-0 enable.
- waddr0  in  ADDR_W  write-port-0 address.
- wdata0  in  DATA_W  write-port-0 data.
- we1  in  1  write-port-1 enable; port 1 has priority over port 0.
- waddr1  in  ADDR_W  write-port-1 address.
- wdata1  in  DATA_W  write-port-1 data.
- sb_set  in  1  mark sb_addr as pending-write.
- sb_addr  in  ADDR_W  scoreboard set address.
- busy  out  DEPTH  scoreboard bits; bit i = entry i has an outstanding write.
- clr_req  in  1  start sequential clear; single-cycle pulse.
- clr_busy  out  1  high while the clear engine runs.

Behaviour:
- Reset (rst_n=0, asynchronous): all entries = 0, busy = 0, clr_busy = 0, engine = IDLE, clear index = 0. Takes effect immediately, including mid-clear.
- Reads: combinational, zero latency.
  - ZERO_R0=1 and address 0: result 0.
  - Otherwise the array contents, subject to the bypass rule below.
- Bypass (BYPASS=1, engine IDLE): if read address equals an effective write address this cycle, return that write's data. Port 1 match takes precedence over port 0.
- BYPASS=0: reads return pre-edge contents; a written value is visible the cycle after the edge.
- Writes at posedge:
  - Port 0 writes when we0; port 1 writes when we1.
  - Both enabled to the same address: wdata1 stored; wdata0 discarded.
  - Address 0 writes are dropped when ZERO_R0=1.
- Scoreboard at posedge:
  - sb_set sets busy[sb_addr].
  - Each effective write clears busy[waddr].
  - Set and clear to the same address in the same cycle: set wins (a new producer has been issued).
  - busy[0] is held at 0 when ZERO_R0=1.
- Clear engine, two states:
  - IDLE: clr_req=1 -> CLEAR with index = 0.
  - CLEAR: each cycle zeroes entry[index] and busy[index], then index+1. After index = DEPTH-1 is processed -> IDLE, index = 0.
  - clr_busy = 1 exactly while in CLEAR; the clear spans DEPTH cycles.
- During CLEAR:
  - we0, we1 and sb_set are ignored; no state change other than the clear.
  - Bypass is disabled; reads return array contents, so some entries are already zeroed and some are stale.
  - clr_req is ignored; no restart.
- Index counter is ADDR_W bits wide; it wraps only on exit from CLEAR.
- No other state exists; all outputs are derived from the array, busy bits and engine state.

Test Plan:
- Reset then read: deassert rst_n, write 32'hDEAD_BEEF to r5 via port 0 -> next cycle rd_data port 0 at addr 5 = 32'hDEAD_BEEF. Addr 0 reads 0 after a write of 32'h1234 to r0.
- Dual-write collision: we0 r7=32'h1111, we1 r7=32'h2222 in the same cycle -> r7 = 32'h2222. During that cycle, with BYPASS=1, a read of r7 returns 32'h2222.
- Bypass on/off: write r3=32'hA5A5 while reading r3 on all NRD ports:
  - BYPASS=1: all ports return 32'hA5A5 in the same cycle.
  - BYPASS=0: old value in that cycle; 32'hA5A5 the next cycle.
- Scoreboard: sb_set r9 -> busy[9]=1 next cycle. Port-1 write r9 -> busy[9]=0. sb_set r9 together with a write to r9 in the same cycle -> busy[9] stays 1.
- Clear engine: fill all entries with nonzero values, pulse clr_req:
  - clr_busy high for exactly DEPTH (32) cycles.
  - A we0 issued during CLEAR has no effect.
  - All entries read 0 afterwards; busy = 0.
- Reset mid-clear: pulse clr_req, drop rst_n at cycle 10 -> clr_busy = 0 and all entries = 0 immediately. A clr_req after reset release starts a fresh clear at index 0.
